// File: rtl/btn_step_debounce.sv
// btn_step_debounce: synchronize and debounce a push-button into step/release strobes with a press counter; optional auto-repeat via AUTO_REPEAT_EN
module btn_step_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES     = 50000,
  parameter int unsigned REPEAT_CYCLES   = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       step_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        s1_q, s2_q;
  logic        level_q, level_d;
  logic        step_q, step_d;
  logic        rel_q, rel_d;
  logic [7:0]  count_q, count_d;
  logic        btn_sync;
  logic        rep_fire;
  assign btn_sync = s2_q;
`ifdef AUTO_REPEAT_EN
  localparam logic [19:0] HOLD_LAST = 20'(HOLD_CYCLES - 1);
  localparam logic [19:0] REP_LAST  = 20'(REPEAT_CYCLES - 1);
  logic [19:0] rep_cnt_q, rep_cnt_d;
  logic        rep_arm_q, rep_arm_d;
  assign rep_fire = state_q == PRESSED && btn_sync && rep_cnt_q == (rep_arm_q ? REP_LAST : HOLD_LAST);
  // repeat timer: first interval is the hold time, later ones the repeat period
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_arm_d = rep_arm_q;
    if (state_d == PRESSED && state_q != PRESSED) begin
      rep_cnt_d = '0;
      rep_arm_d = 1'b0;
    end else if (rep_fire) begin
      rep_cnt_d = '0;
      rep_arm_d = 1'b1;
    end else if (state_q == PRESSED && state_d == PRESSED) begin
      rep_cnt_d = rep_cnt_q + 20'd1;
    end
  end
  // repeat timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
    end
  end
`else
  assign rep_fire = 1'b0 & |{HOLD_CYCLES, REPEAT_CYCLES};
`endif
  // debounce FSM next state and registered-output next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: if (btn_sync) begin
        state_d = PRESS_WAIT;
        cnt_d   = 20'd1;
      end
      PRESS_WAIT: if (!btn_sync) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == DB_LAST) begin
        state_d = PRESSED;
        cnt_d   = '0;
        step_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
      PRESSED: if (!btn_sync) begin
        state_d = RELEASE_WAIT;
        cnt_d   = 20'd1;
      end else begin
        step_d = rep_fire;
      end
      RELEASE_WAIT: if (btn_sync) begin
        state_d = PRESSED;
        cnt_d   = '0;
      end else if (cnt_q == DB_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        rel_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = state_d == PRESSED || state_d == RELEASE_WAIT;
    count_d = count_q + 8'(step_d);
  end
  // synchronizer, FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      step_q  <= 1'b0;
      rel_q   <= 1'b0;
      count_q <= '0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      step_q  <= step_d;
      rel_q   <= rel_d;
      count_q <= count_d;
    end
  end
  assign btn_level     = level_q;
  assign step_pulse    = step_q;
  assign release_pulse = rel_q;
  assign press_count   = count_q;
endmodule

// File: tb/tb_btn_step_debounce.sv
// tb_btn_step_debounce: table-driven and scoreboarded check of btn_step_debounce
module tb_btn_step_debounce;
  typedef struct {
    logic       rst;
    logic       raw;
    logic       stp;
    logic       rel;
    logic       lvl;
    logic [7:0] cnt;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       btn_level, step_pulse, release_pulse;
  logic [7:0] press_count;
  vec_t       tbl[$];
  vec_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         idx = 0;
  btn_step_debounce #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .step_pulse(step_pulse), .release_pulse(release_pulse), .press_count(press_count)
  );
  always #5 clk = ~clk;
  task automatic add(input int n, input logic r, input logic b, input logic s, input logic l_p,
                     input logic lv, input logic [7:0] c);
    vec_t v;
    v = '{r, b, s, l_p, lv, c};
    repeat (n) tbl.push_back(v);
  endtask
  task automatic cyc(input vec_t v, input string name);
    vec_t e;
    rst = v.rst;
    btn_raw = v.raw;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({step_pulse, release_pulse, btn_level, press_count} !== {e.stp, e.rel, e.lvl, e.cnt}) begin
      n_err++;
      $display("FAIL %s[%0d]: got step=%b rel=%b lvl=%b cnt=%0d, want step=%b rel=%b lvl=%b cnt=%0d",
               name, idx, step_pulse, release_pulse, btn_level, press_count, e.stp, e.rel, e.lvl, e.cnt);
    end
    idx++;
  endtask
  task automatic run(input int n, input logic r, input logic b, input logic s, input logic l_p,
                     input logic lv, input logic [7:0] c, input string name);
    vec_t v;
    v = '{r, b, s, l_p, lv, c};
    repeat (n) cyc(v, name);
  endtask
  initial begin
    logic [7:0] c;
    logic       s;
    add(2, 1, 0, 0, 0, 0, 0);
    add(5, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1, 1);
    add(2, 0, 1, 0, 0, 1, 1);
    add(5, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1);
    for (int g = 0; g < 5; g++) begin
      add(3, 0, 1, 0, 0, 0, 1);
      add(2, 0, 0, 0, 0, 0, 1);
    end
    add(2, 0, 0, 0, 0, 0, 1);
    add(5, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 1, 2);
    add(1, 0, 1, 0, 0, 1, 2);
    add(2, 0, 0, 0, 0, 1, 2);
    add(6, 0, 1, 0, 0, 1, 2);
    add(5, 0, 0, 0, 0, 1, 2);
    add(1, 0, 0, 0, 1, 0, 2);
    add(2, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], "table");
    c = 8'd2;
    for (int p = 0; p < 254; p++) begin
      run(5, 0, 1, 0, 0, 0, c, "wrap_press");
      c = c + 8'd1;
      run(1, 0, 1, 1, 0, 1, c, "wrap_step");
      run(1, 0, 1, 0, 0, 1, c, "wrap_hold");
      run(5, 0, 0, 0, 0, 1, c, "wrap_rel_wait");
      run(1, 0, 0, 0, 1, 0, c, "wrap_release");
      run(1, 0, 0, 0, 0, 0, c, "wrap_idle");
    end
    n_cmp++;
    if (press_count !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_final: got cnt=%0d, want cnt=0", press_count);
    end
    run(4, 0, 1, 0, 0, 0, 0, "rst_pw_count");
    run(1, 1, 1, 0, 0, 0, 0, "rst_mid_pw");
    run(5, 0, 1, 0, 0, 0, 0, "held_thru_rst");
    run(1, 0, 1, 1, 0, 1, 1, "held_thru_rst_step");
    c = 8'd1;
    for (int k = 1; k <= 25; k++) begin
`ifdef AUTO_REPEAT_EN
      s = k >= 8 && k <= 19 && (k - 8) % 3 == 0;
`else
      s = 1'b0;
`endif
      c = c + 8'(s);
      run(1, 0, k <= 17, s, k == 23, k < 23, c, "hold_release");
    end
    n_cmp++;
`ifdef AUTO_REPEAT_EN
    if (press_count !== 8'd5) begin
      n_err++;
      $display("FAIL repeat_count: got cnt=%0d, want cnt=5", press_count);
    end
`else
    if (press_count !== 8'd1) begin
      n_err++;
      $display("FAIL single_count: got cnt=%0d, want cnt=1", press_count);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
